// File: rtl/regfile_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the register-file write-port controller.
//   NUM_REGS / ADDR_W / DATA_W : register file geometry
//   state_e                    : controller state (clear sweep, normal run)
//   req_e                      : requester IDs, also the grant bit positions
//   REG_ZERO                   : hard-wired zero register address
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;

   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Writeback bus between the two requesters (ALU, load unit), the write-port
// controller and the register file write port.
//   alu_valid/alu_ready/alu_reg/alu_data : ALU writeback channel
//   mem_valid/mem_ready/mem_reg/mem_data : load writeback channel
//   RegWrite/Write_reg/Write_data        : register file write port
// modport master : requester / register-file side (drives requests)
// modport slave  : controller side (drives readies and the write port)
// -----------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) ();

   logic              alu_valid;
   logic              alu_ready;
   logic [ADDR_W-1:0] alu_reg;
   logic [DATA_W-1:0] alu_data;

   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_reg;
   logic [DATA_W-1:0] mem_data;

   logic              RegWrite;
   logic [ADDR_W-1:0] Write_reg;
   logic [DATA_W-1:0] Write_data;

   modport master (
      output alu_valid, alu_reg, alu_data,
      output mem_valid, mem_reg, mem_data,
      input  alu_ready, mem_ready,
      input  RegWrite, Write_reg, Write_data
   );

   modport slave (
      input  alu_valid, alu_reg, alu_data,
      input  mem_valid, mem_reg, mem_data,
      output alu_ready, mem_ready,
      output RegWrite, Write_reg, Write_data
   );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter with a registered priority pointer.
//   clk, reset : clock, synchronous active-high reset (priority -> REQ_ALU)
//   en         : when low, no grant is issued
//   advance    : when high, a grant moves priority to the other requester
//   valid[1:0] : requests, indexed by req_e
//   gnt[1:0]   : one-hot grant (combinational), indexed by req_e
//   prio       : current priority pointer
// -----------------------------------------------------------------------------
module rr_arb2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       advance,
   input  logic [1:0] valid,
   output logic [1:0] gnt,
   output req_e       prio
);

   req_e prio_q, prio_d;

   // Priority only matters on contention; a lone request always wins.
   always_comb begin
      gnt = '0;
      if (en) begin
         if (valid == 2'b11) begin
            gnt = (prio_q == REQ_ALU) ? 2'b01 : 2'b10;
         end else begin
            gnt = valid;
         end
      end
   end

   always_comb begin
      prio_d = prio_q;
      if (advance && gnt[REQ_ALU]) begin
         prio_d = REQ_MEM;
      end else if (advance && gnt[REQ_MEM]) begin
         prio_d = REQ_ALU;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio_q <= REQ_ALU;
      end else begin
         prio_q <= prio_d;
      end
   end

   assign prio = prio_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Write-port controller for a 32x32 register file with a single write port.
// After reset it sweeps every register to INIT_VALUE, then shares the write
// port between the ALU and load writeback channels round-robin, through a
// one-cycle registered output stage. Writes to register 0 are accepted and
// dropped so that register 0 stays zero.
//   clk, reset : clock, synchronous active-high reset
//   wb         : writeback bus (slave side): requests, readies, write port
//   init_done  : high once the clear sweep has completed
//   wr_count   : committed writes in RUN, saturating
//   drop_count : accepted writes to register 0, saturating
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int                           NUM_REGS   = regfile_pkg::NUM_REGS,
   parameter int                           ADDR_W     = regfile_pkg::ADDR_W,
   parameter int                           DATA_W     = regfile_pkg::DATA_W,
   parameter logic [regfile_pkg::DATA_W-1:0] INIT_VALUE = '0,
   parameter int                           CNT_W      = 16
) (
   input  logic                clk,
   input  logic                reset,
   regfile_wb_arbiter_if.slave wb,
   output logic                init_done,
   output logic [CNT_W-1:0]    wr_count,
   output logic [CNT_W-1:0]    drop_count
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              reg_write_q, reg_write_d;
   logic [ADDR_W-1:0] write_reg_q, write_reg_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;
   logic              init_done_q, init_done_d;
   logic [CNT_W-1:0]  wr_count_q, wr_count_d;
   logic [CNT_W-1:0]  drop_count_q, drop_count_d;

   logic              run;
   logic [1:0]        gnt;
   req_e              prio;
   logic [ADDR_W-1:0] sel_reg;
   logic [DATA_W-1:0] sel_data;

   assign run = (state_q == ST_RUN);

   // Every grant is a transfer (grant implies valid), so priority advances
   // whenever the arbiter is enabled.
   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .en      (run),
      .advance (run),
      .valid   ({wb.mem_valid, wb.alu_valid}),
      .gnt     (gnt),
      .prio    (prio)
   );

   assign wb.alu_ready = gnt[REQ_ALU];
   assign wb.mem_ready = gnt[REQ_MEM];

   assign sel_reg  = gnt[REQ_MEM] ? wb.mem_reg  : wb.alu_reg;
   assign sel_data = gnt[REQ_MEM] ? wb.mem_data : wb.alu_data;

   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned; an unassigned path would infer a latch.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      reg_write_d  = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      init_done_d  = init_done_q;
      wr_count_d   = wr_count_q;
      drop_count_d = drop_count_q;

      case (state_q)
         // NOTE: the register file array has no reset of its own (a reset
         // on a RAM array blocks RAM inference), so its contents are set by
         // this sweep through the normal write port instead.
         ST_INIT: begin
            reg_write_d  = 1'b1;
            write_reg_d  = idx_q;
            write_data_d = INIT_VALUE;
            idx_d        = idx_q + 1'b1;
            if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Registered one edge after the last sweep write lands.
            init_done_d = 1'b1;
            if (|gnt) begin
               write_reg_d  = sel_reg;
               write_data_d = sel_data;
               if (sel_reg != ADDR_W'(REG_ZERO)) begin
                  reg_write_d = 1'b1;
                  wr_count_d  = sat_inc(wr_count_q);
               end else begin
                  drop_count_d = sat_inc(drop_count_q);
               end
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // NOTE: non-blocking assignments here so every flop samples the values
   // from before this edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_INIT;
         idx_q        <= '0;
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
         init_done_q  <= 1'b0;
         wr_count_q   <= '0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
         init_done_q  <= init_done_d;
         wr_count_q   <= wr_count_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign wb.RegWrite   = reg_write_q;
   assign wb.Write_reg  = write_reg_q;
   assign wb.Write_data = write_data_q;
   assign init_done     = init_done_q;
   assign wr_count      = wr_count_q;
   assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Scoreboard bench for regfile_wb_arbiter. Stimulus pushes each expected
// register-file write into a queue; a monitor pops and compares on every
// cycle that RegWrite is high, and keeps a model of the register file.
// Counters are built 2 bits wide so saturation is reached quickly.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

   localparam int TB_CNT_W = 2;
   localparam logic [TB_CNT_W-1:0] CNT_MAX = '1;

   typedef struct {
      logic [4:0]          addr;
      logic [31:0]         data;
      logic [TB_CNT_W-1:0] wcnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic init_done;
   logic [TB_CNT_W-1:0] wr_count, drop_count;

   regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32)) wb ();

   regfile_wb_arbiter #(
      .NUM_REGS   (32),
      .ADDR_W     (5),
      .DATA_W     (32),
      .INIT_VALUE (32'h0),
      .CNT_W      (TB_CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wb         (wb),
      .init_done  (init_done),
      .wr_count   (wr_count),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   exp_t exp_q[$];
   logic [31:0] rf_model [32];
   logic [TB_CNT_W-1:0] exp_wr = '0;
   logic [TB_CNT_W-1:0] exp_drop = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every register-file write must match the head of the queue.
   always @(negedge clk) begin
      if (wb.RegWrite === 1'b1) begin
         rf_model[wb.Write_reg] = wb.Write_data;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected write: got reg %0d data 0x%0h, expected no write",
                     wb.Write_reg, wb.Write_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("write addr", 32'(wb.Write_reg), 32'(e.addr));
            check("write data", wb.Write_data, e.data);
            check("wr_count at write", 32'(wr_count), 32'(e.wcnt));
         end
      end
   end

   task automatic expect_commit(input logic [4:0] r, input logic [31:0] d);
      exp_t e;
      if (r != 5'd0) begin
         if (exp_wr != CNT_MAX) exp_wr = exp_wr + 1'b1;
         e.addr = r;
         e.data = d;
         e.wcnt = exp_wr;
         exp_q.push_back(e);
      end else begin
         if (exp_drop != CNT_MAX) exp_drop = exp_drop + 1'b1;
      end
   endtask

   // One cycle of stimulus: drive after the edge, check the combinational
   // readies, and queue the write each hand-predicted grant will produce.
   task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic ea, input logic em, input string tag);
      @(posedge clk);
      #1;
      wb.alu_valid = av;
      wb.alu_reg   = ar;
      wb.alu_data  = ad;
      wb.mem_valid = mv;
      wb.mem_reg   = mr;
      wb.mem_data  = md;
      #1;
      check({tag, " alu_ready"}, 32'(wb.alu_ready), 32'(ea));
      check({tag, " mem_ready"}, 32'(wb.mem_ready), 32'(em));
      if (ea) expect_commit(ar, ad);
      if (em) expect_commit(mr, md);
   endtask

   task automatic idle(input string tag);
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, tag);
   endtask

   // Holds reset for two edges (checking reset values), then releases it and
   // follows the 32-cycle clear sweep until init_done rises.
   task automatic reset_and_sweep(input string tag);
      int done_at;
      exp_t e;
      reset = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         wb.alu_valid = 1'b0;
         wb.mem_valid = 1'b0;
         check({tag, " RegWrite in reset"}, 32'(wb.RegWrite), 32'h0);
         check({tag, " Write_reg in reset"}, 32'(wb.Write_reg), 32'h0);
         check({tag, " Write_data in reset"}, wb.Write_data, 32'h0);
         check({tag, " init_done in reset"}, 32'(init_done), 32'h0);
         check({tag, " wr_count in reset"}, 32'(wr_count), 32'h0);
         check({tag, " drop_count in reset"}, 32'(drop_count), 32'h0);
      end
      exp_wr   = '0;
      exp_drop = '0;
      for (int i = 0; i < 32; i++) begin
         e.addr = 5'(i);
         e.data = 32'h0;
         e.wcnt = '0;
         exp_q.push_back(e);
      end
      reset = 1'b0;
      done_at = 0;
      for (int k = 1; k <= 40 && done_at == 0; k++) begin
         @(posedge clk);
         #1;
         if (k <= 32) check({tag, " sweep RegWrite"}, 32'(wb.RegWrite), 32'h1);
         if (init_done !== 1'b1) begin
            check({tag, " readies during init"}, 32'(wb.alu_ready | wb.mem_ready), 32'h0);
         end else begin
            done_at = k;
         end
      end
      check({tag, " init_done edge"}, done_at, 33);
      check({tag, " RegWrite after sweep"}, 32'(wb.RegWrite), 32'h0);
      check({tag, " sweep writes all seen"}, exp_q.size(), 0);
   endtask

   initial begin
      wb.alu_valid = 1'b0;
      wb.alu_reg   = '0;
      wb.alu_data  = '0;
      wb.mem_valid = 1'b0;
      wb.mem_reg   = '0;
      wb.mem_data  = '0;

      // Power-on reset and clear sweep.
      reset_and_sweep("por");

      // Single ALU write to reg 8 (priority moves to MEM).
      step(1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "alu8");
      idle("alu8 commit");
      check("alu8 wr_count", 32'(wr_count), 32'h1);
      idle("alu8 after");
      check("alu8 RegWrite drops", 32'(wb.RegWrite), 32'h0);

      // Load write to reg 0: accepted, dropped (priority moves back to ALU).
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b1, "zero");
      idle("zero commit");
      check("zero RegWrite", 32'(wb.RegWrite), 32'h0);
      check("zero drop_count", 32'(drop_count), 32'(exp_drop));
      check("zero wr_count", 32'(wr_count), 32'(exp_wr));

      // Both requesters continuously valid: ALU, MEM, ALU, MEM; wr_count saturates.
      step(1'b1, 5'd9, 32'h1, 1'b1, 5'd10, 32'h2, 1'b1, 1'b0, "rr1");
      step(1'b1, 5'd9, 32'h1, 1'b1, 5'd10, 32'h2, 1'b0, 1'b1, "rr2");
      step(1'b1, 5'd9, 32'h1, 1'b1, 5'd10, 32'h2, 1'b1, 1'b0, "rr3");
      step(1'b1, 5'd9, 32'h1, 1'b1, 5'd10, 32'h2, 1'b0, 1'b1, "rr4");
      idle("rr drain");
      idle("rr drain");
      check("rr wr_count saturated", 32'(wr_count), 32'(CNT_MAX));

      // Same destination: ALU 0xAA lands first, MEM 0xBB last.
      step(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB, 1'b1, 1'b0, "same1");
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hBB, 1'b0, 1'b1, "same2");
      idle("same drain");
      idle("same drain");
      check("reg5 final value", rf_model[5], 32'hBB);

      // Reset during continuous ALU traffic; the write accepted in the
      // reset cycle is lost.
      step(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "traffic1");
      step(1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "traffic2");
      step(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "traffic3");
      @(posedge clk);
      #1;
      wb.alu_data = 32'h44;
      reset_and_sweep("midrst");

      // Five committed writes with a 2-bit counter leave wr_count at 3.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 5'd7, 32'(i + 100), 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, "sat");
      end
      idle("sat drain");
      idle("sat drain");
      check("sat wr_count", 32'(wr_count), 32'h3);
      check("sat drop_count", 32'(drop_count), 32'h0);
      check("reg7 final value", rf_model[7], 32'd104);
      check("scoreboard empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion before 100000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule
